// File: rtl/ddr_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is held in a
// register so rdata stays stable (last value) while the FIFO is empty.
module ddr_sync_fifo #(
  parameter int w     = 16,
  parameter int depth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [w-1:0]           wdata,
  input  logic                   rd,
  output logic [w-1:0]           rdata,
  output logic [$clog2(depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(depth);

  logic [w-1:0]  r_mem [depth];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic [w-1:0]  r_head;

  logic          w_pop;
  logic          w_push;
  logic [AW:0]   w_left;
  logic [AW-1:0] w_rp_nxt;
  logic [w-1:0]  w_head_nxt;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (AW+1)'(depth));
  assign w_pop  = rd && !empty;
  // A full FIFO still accepts a write when the head leaves at the same edge.
  assign w_push = wr && (!full || w_pop);
  assign w_left = r_count - (AW+1)'(w_pop);
  assign w_rp_nxt = r_rp + AW'(w_pop);

  assign rdata = r_head;
  assign count = r_count;

  // Next head: the oldest surviving stored entry, else the incoming word, else hold.
  always_comb begin
    w_head_nxt = r_head;
    if (w_left != '0)
      w_head_nxt = r_mem[w_rp_nxt];
    else if (w_push)
      w_head_nxt = wdata;
  end

  // Storage array; contents need no reset because the head register masks them.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp] <= wdata;
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      r_head <= w_head_nxt;
      r_rp   <= w_rp_nxt;
      if (w_push)
        r_wp <= r_wp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_in_fifo.sv
// n-pin DDR receiver: captures both clock edges, re-pairs each rising sample
// with the following falling sample and buffers the pairs in an FWFT FIFO.
module ddr_in_fifo #(
  parameter int n     = 8,
  parameter int depth = 16,
  parameter int sim   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n-1:0]           pin,
  input  logic                   en,
  output logic [n-1:0]           data_p,
  output logic [n-1:0]           data_n,
  output logic                   valid,
  input  logic                   ready,
  output logic [$clog2(depth):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int AW = $clog2(depth);

  logic [n-1:0]   w_cap_p;
  logic [n-1:0]   w_cap_n;
  logic           r_en_d;
  logic [2*n-1:0] r_pair;
  logic           r_wr;
  logic           r_ovf;
  logic [2*n-1:0] w_rdata;
  logic [AW:0]    w_count;
  logic           w_full;
  logic           w_empty;
  logic           w_drop;

  if (sim != 0) begin : g_beh
    logic [n-1:0] r_cap_p;
    logic [n-1:0] r_cap_n;

    // Rising-edge sample of all pins.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cap_p <= '0;
      else     r_cap_p <= pin;
    end

    // Falling-edge sample of all pins.
    always_ff @(negedge clk or posedge rst) begin
      if (rst) r_cap_n <= '0;
      else     r_cap_n <= pin;
    end

    assign w_cap_p = r_cap_p;
    assign w_cap_n = r_cap_n;
  end else begin : g_cell
    for (genvar i = 0; i < n; i++) begin : g_pin
      // One DDR input cell per pin; these registers are meant to be packed
      // into the pin's IO tile (rising capture D_IN_0, falling capture D_IN_1).
      logic r_d0;
      logic r_d1;

      // Rising-edge capture register of this pin.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_d0 <= 1'b0;
        else     r_d0 <= pin[i];
      end

      // Falling-edge capture register of this pin.
      always_ff @(negedge clk or posedge rst) begin
        if (rst) r_d1 <= 1'b0;
        else     r_d1 <= pin[i];
      end

      assign w_cap_p[i] = r_d0;
      assign w_cap_n[i] = r_d1;
    end
  end

  // en travels with the p-sample; the pair is assembled once the n-sample exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_d <= 1'b0;
      r_pair <= '0;
      r_wr   <= 1'b0;
    end else begin
      r_en_d <= en;
      r_pair <= {w_cap_p, w_cap_n};
      r_wr   <= r_en_d;
    end
  end

  ddr_sync_fifo #(
    .w     (2*n),
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (r_wr),
    .wdata (r_pair),
    .rd    (ready),
    .rdata (w_rdata),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_drop = r_wr && w_full && !(ready && !w_empty);

  // Sticky overflow; a drop at the same edge as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  assign data_p   = w_rdata[2*n-1:n];
  assign data_n   = w_rdata[n-1:0];
  assign valid    = !w_empty;
  assign count    = w_count;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_ddr_in_fifo.sv
// Directed bench for ddr_in_fifo (n=8, depth=4, behavioural capture).
module tb_ddr_in_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin;
  logic       en;
  logic [7:0] data_p;
  logic [7:0] data_n;
  logic       valid;
  logic       ready;
  logic [2:0] count;
  logic       overflow;
  logic       clr_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  ddr_in_fifo #(.n(8), .depth(4), .sim(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .pin      (pin),
    .en       (en),
    .data_p   (data_p),
    .data_n   (data_n),
    .valid    (valid),
    .ready    (ready),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       e;
    logic       r;
    logic       ev;
    logic [7:0] edp;
    logic [7:0] edn;
    logic [2:0] ec;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One DDR bit-cell: a ahead of posedge, b ahead of negedge; returns at negedge+1.
  task automatic step(input logic [7:0] a, input logic [7:0] b,
                      input logic e, input logic r, input logic c);
    pin = a; en = e; ready = r; clr_ovf = c;
    @(posedge clk);
    #2 pin = b;
    @(negedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic e,
                              input logic r, input logic ev, input logic [7:0] edp,
                              input logic [7:0] edn, input logic [2:0] ec);
    vec_t v;
    v.a = a; v.b = b; v.e = e; v.r = r; v.ev = ev; v.edp = edp; v.edn = edn; v.ec = ec;
    return v;
  endfunction

  initial begin
    int pops;
    logic [7:0] nxt;

    // single pair, then en gaps 1,0,1,1, then push into empty with ready=1
    tbl[0]  = mk(8'hA5, 8'h3C, 1, 0, 0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    tbl[2]  = mk(8'h00, 8'h00, 0, 0, 1, 8'hA5, 8'h3C, 1);
    tbl[3]  = mk(8'h00, 8'h00, 0, 1, 0, 8'hA5, 8'h3C, 0);
    tbl[4]  = mk(8'h11, 8'h22, 1, 0, 0, 8'hA5, 8'h3C, 0);
    tbl[5]  = mk(8'h33, 8'h44, 0, 0, 0, 8'hA5, 8'h3C, 0);
    tbl[6]  = mk(8'h55, 8'h66, 1, 0, 1, 8'h11, 8'h22, 1);
    tbl[7]  = mk(8'h77, 8'h88, 1, 0, 1, 8'h11, 8'h22, 1);
    tbl[8]  = mk(8'h00, 8'h00, 0, 0, 1, 8'h11, 8'h22, 2);
    tbl[9]  = mk(8'h00, 8'h00, 0, 0, 1, 8'h11, 8'h22, 3);
    tbl[10] = mk(8'h00, 8'h00, 0, 1, 1, 8'h55, 8'h66, 2);
    tbl[11] = mk(8'h00, 8'h00, 0, 1, 1, 8'h77, 8'h88, 1);
    tbl[12] = mk(8'h00, 8'h00, 0, 1, 0, 8'h77, 8'h88, 0);
    tbl[13] = mk(8'h00, 8'h00, 0, 1, 0, 8'h77, 8'h88, 0);
    tbl[14] = mk(8'h99, 8'hAA, 1, 1, 0, 8'h77, 8'h88, 0);
    tbl[15] = mk(8'h00, 8'h00, 0, 1, 0, 8'h77, 8'h88, 0);
    tbl[16] = mk(8'h00, 8'h00, 0, 1, 1, 8'h99, 8'hAA, 1);
    tbl[17] = mk(8'h00, 8'h00, 0, 1, 0, 8'h99, 8'hAA, 0);

    rst = 1'b1; pin = '0; en = 0; ready = 0; clr_ovf = 0;
    #21;
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", {data_p, data_n}, 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].r, 0);
      chk($sformatf("vec%0d_valid", i), valid, tbl[i].ev);
      chk($sformatf("vec%0d_count", i), count, tbl[i].ec);
      chk($sformatf("vec%0d_data", i), {data_p, data_n}, {tbl[i].edp, tbl[i].edn});
      chk($sformatf("vec%0d_ovf", i), overflow, 0);
    end

    // streaming: 8 pairs back to back with ready=1
    for (int j = 0; j < 11; j++) begin
      step(8'(j), ~8'(j), j < 8, 1, 0);
      if (j >= 2 && j <= 9) begin
        chk($sformatf("stream%0d_valid", j), valid, 1);
        chk($sformatf("stream%0d_data", j), {data_p, data_n}, {8'(j-2), ~8'(j-2)});
      end
      chk($sformatf("stream%0d_cntle1", j), count <= 3'd1, 1);
      chk($sformatf("stream%0d_ovf", j), overflow, 0);
    end
    chk("stream_end_valid", valid, 0);

    // overflow: 6 pairs into depth 4; clr at the second drop must lose to set
    for (int j = 0; j < 8; j++) begin
      step(8'h20 + 8'(j), 8'hD0 + 8'(j), j < 6, 0, j == 7);
      if (j == 6) chk("ovf_first_drop", overflow, 1);
    end
    chk("ovf_count", count, 4);
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_head", {data_p, data_n}, {8'h20, 8'hD0});
    step(0, 0, 0, 0, 1);
    chk("ovf_cleared", overflow, 0);
    chk("ovf_count_kept", count, 4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain%0d_valid", j), valid, 1);
      chk($sformatf("drain%0d_data", j), {data_p, data_n}, {8'h20 + 8'(j), 8'hD0 + 8'(j)});
      step(0, 0, 0, 1, 0);
    end
    chk("drain_empty", valid, 0);
    chk("drain_count", count, 0);

    // full with simultaneous push and pop
    for (int j = 0; j < 6; j++) step(8'h40 + 8'(j), 8'hB0 + 8'(j), 1, 0, 0);
    chk("full_count", count, 4);
    pops = 0;
    nxt = 8'h40;
    for (int j = 6; j < 16; j++) begin
      if (valid) begin
        chk($sformatf("full_pop%0d", pops), {data_p, data_n}, {nxt, nxt + 8'h70});
        nxt++;
        pops++;
      end
      step(8'h40 + 8'(j), 8'hB0 + 8'(j), j <= 9, 1, 0);
      if (j <= 11) chk($sformatf("full_pp%0d_count", j), count, 4);
      chk($sformatf("full_pp%0d_ovf", j), overflow, 0);
    end
    chk("full_pops", pops, 10);
    chk("full_end_valid", valid, 0);

    // asynchronous reset mid-stream
    for (int j = 0; j < 5; j++) step(8'h60 + 8'(j), 8'h90 + 8'(j), j < 3, 0, 0);
    chk("prerst_count", count, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_count", count, 0);
    chk("arst_ovf", overflow, 0);
    step(8'hEE, 8'hEE, 1, 0, 0);
    rst = 1'b0;
    step(8'h5A, 8'hA5, 1, 0, 0);
    chk("post_rst_lat1", valid, 0);
    step(0, 0, 0, 0, 0);
    chk("post_rst_lat2", valid, 0);
    step(0, 0, 0, 0, 0);
    chk("post_rst_valid", valid, 1);
    chk("post_rst_data", {data_p, data_n}, {8'h5A, 8'hA5});
    step(0, 0, 0, 0, 0);
    chk("post_rst_count", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
